div_fp_seq: RTL

DIV_FP_SEQ -- requirements
Module: div_fp_seq

---
 rtl/fp_pkg.sv | 54 +++++
 rtl/fp_unpack.sv | 58 +++++
 rtl/div_fp_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 helpers for the sequential FP units: format derivation,
// exception flag indices, FSM/class enums and canonical special encodings.
package fp_pkg;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;
    localparam int NFLAGS  = 5;

    function automatic int exp_w(input int t);
        return (t == 16) ? 5 : 8;
    endfunction

    function automatic int frac_w(input int t);
        return (t == 16) ? 10 : 23;
    endfunction

    function automatic int bias_of(input int t);
        return (t == 16) ? 15 : 127;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_DIVIDE,
        ST_ROUND,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Encodings are kept in a 32-bit word; the narrow format sits in the low half.
    localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
    localparam logic [31:0] INF32  = 32'h7F80_0000;
    localparam logic [31:0] QNAN16 = 32'h0000_7E00;
    localparam logic [31:0] INF16  = 32'h0000_7C00;

    function automatic logic [31:0] qnan_word(input int t);
        return (t == 16) ? QNAN16 : QNAN32;
    endfunction

    function automatic logic [31:0] inf_word(input int t);
        return (t == 16) ? INF16 : INF32;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand classifier: splits an IEEE-754 word into sign, class,
// unbiased exponent and a significand with the leading one at bit FRAC.
module fp_unpack
    import fp_pkg::*;
#(
    parameter  int TYPE = 32,
    localparam int EXP  = exp_w(TYPE),
    localparam int FRAC = frac_w(TYPE),
    localparam int EW   = EXP + 3
) (
    input  logic [TYPE-1:0]        bits_i,
    output logic                   sign_o,
    output fp_class_e              cls_o,
    output logic signed [EW-1:0]   exp_o,
    output logic [FRAC:0]          mant_o
);

    localparam int BIAS = bias_of(TYPE);
    localparam int SW   = $clog2(FRAC + 1);

    logic [EXP-1:0]  exp_field;
    logic [FRAC-1:0] frac_field;
    logic [SW-1:0]   lz;

    assign exp_field  = bits_i[TYPE-2 -: EXP];
    assign frac_field = bits_i[FRAC-1:0];

    // Upward scan: the last hit is the highest set bit, i.e. the smallest shift.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        lz = '0;
        for (int i = 0; i < FRAC; i++) begin
            if (frac_field[i]) lz = SW'(FRAC - i);
        end
    end

    always_comb begin
        sign_o = bits_i[TYPE-1];
        cls_o  = CLS_NORM;
        exp_o  = EW'(int'(exp_field) - BIAS);
        mant_o = {1'b1, frac_field};
        if (exp_field == '0) begin
            if (frac_field == '0) begin
                cls_o  = CLS_ZERO;
                exp_o  = '0;
                mant_o = '0;
            end else begin
                cls_o  = CLS_SUB;
                exp_o  = EW'(1 - BIAS - int'(lz));
                mant_o = {1'b0, frac_field} << lz;
            end
        end else if (exp_field == '1) begin
            cls_o = (frac_field == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/div_fp_seq.sv
// Sequential IEEE-754 divider: two-cycle unpack, radix-2 restoring recurrence
// (one quotient bit per cycle), round-to-nearest-even, valid/ready on both sides.
module div_fp_seq
    import fp_pkg::*;
#(
    parameter int TYPE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TYPE-1:0] a_bits,
    input  logic [TYPE-1:0] b_bits,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [TYPE-1:0] result_bits,
    output logic [4:0]      except_flags,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int EXP  = exp_w(TYPE);
    localparam int FRAC = frac_w(TYPE);
    localparam int BIAS = bias_of(TYPE);
    localparam int EW   = EXP + 3;
    localparam int RW   = FRAC + 2;
    localparam int QW   = FRAC + 3;
    localparam int CW   = $clog2(FRAC + 3);

    localparam logic [31:0]          QNAN_W = qnan_word(TYPE);
    localparam logic [31:0]          INF_W  = inf_word(TYPE);
    localparam logic [TYPE-1:0]      QNAN   = QNAN_W[TYPE-1:0];
    localparam logic [TYPE-1:0]      INF    = INF_W[TYPE-1:0];
    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] MAX_S  = EW'((1 << EXP) - 1);
    localparam logic [CW-1:0]        LAST   = CW'(FRAC + 2);

    state_e state_q, state_d;

    logic [TYPE-1:0] a_q, b_q;
    logic            phase_q;
    logic [TYPE-1:0] result_q;
    logic [4:0]      flags_q;

    logic                 sa_q, sb_q, sign_q;
    fp_class_e            ca_q, cb_q;
    logic signed [EW-1:0] ea_q, eb_q, exp_q;
    logic [FRAC:0]        ma_q, mb_q;
    logic [RW-1:0]        rem_q;
    logic [QW-1:0]        quo_q;
    logic [CW-1:0]        cnt_q;

    logic                 ua_sign, ub_sign;
    fp_class_e            ua_cls, ub_cls;
    logic signed [EW-1:0] ua_exp, ub_exp;
    logic [FRAC:0]        ua_mant, ub_mant;

    fp_unpack #(.TYPE(TYPE)) u_unpack_a (
        .bits_i (a_q),
        .sign_o (ua_sign),
        .cls_o  (ua_cls),
        .exp_o  (ua_exp),
        .mant_o (ua_mant)
    );

    fp_unpack #(.TYPE(TYPE)) u_unpack_b (
        .bits_i (b_q),
        .sign_o (ub_sign),
        .cls_o  (ub_cls),
        .exp_o  (ub_exp),
        .mant_o (ub_mant)
    );

    // Special-operand resolution from the registered classes.
    logic            special_d;
    logic [TYPE-1:0] sp_res_d;
    logic [4:0]      sp_flags_d;
    logic            q_sign;
    logic            a_fin_nz;

    assign q_sign   = sa_q ^ sb_q;
    assign a_fin_nz = (ca_q == CLS_SUB) || (ca_q == CLS_NORM);

    always_comb begin
        special_d  = 1'b1;
        sp_res_d   = '0;
        sp_flags_d = '0;
        if (ca_q == CLS_NAN || cb_q == CLS_NAN ||
            (ca_q == CLS_ZERO && cb_q == CLS_ZERO) ||
            (ca_q == CLS_INF && cb_q == CLS_INF)) begin
            sp_res_d           = QNAN;
            sp_flags_d[FLAG_NV] = 1'b1;
        end else if (a_fin_nz && cb_q == CLS_ZERO) begin
            sp_res_d           = {q_sign, INF[TYPE-2:0]};
            sp_flags_d[FLAG_DZ] = 1'b1;
        end else if (ca_q == CLS_INF) begin
            sp_res_d = {q_sign, INF[TYPE-2:0]};
        end else if (ca_q == CLS_ZERO || cb_q == CLS_INF) begin
            sp_res_d = {q_sign, {(TYPE-1){1'b0}}};
        end else begin
            special_d = 1'b0;
        end
    end

    // Pre-align keeps the dividend in [mb, 2mb) so every quotient starts 1.x.
    logic                 pre_lt;
    logic [RW-1:0]        dividend;
    logic signed [EW-1:0] exp_pre_d;
    logic [RW-1:0]        rem_cur, rem_diff, rem_d;
    logic [QW-1:0]        quo_cur, quo_d;
    logic                 q_bit;

    assign pre_lt    = ma_q < mb_q;
    assign dividend  = pre_lt ? {ma_q, 1'b0} : {1'b0, ma_q};
    assign exp_pre_d = ea_q - eb_q + BIAS_S - (pre_lt ? ONE_S : '0);

    always_comb begin
        rem_cur  = (state_q == ST_DIVIDE) ? rem_q : dividend;
        quo_cur  = (state_q == ST_DIVIDE) ? quo_q : '0;
        q_bit    = rem_cur >= {1'b0, mb_q};
        rem_diff = q_bit ? rem_cur - {1'b0, mb_q} : rem_cur;
        rem_d    = rem_diff << 1;
        quo_d    = {quo_cur[QW-2:0], q_bit};
    end

    // Rounding and range checks on the finished quotient.
    logic [FRAC:0]        rd_mant;
    logic                 rd_g, rd_r, rd_s, rd_inc, rd_carry;
    logic [FRAC+1:0]      rd_sum;
    logic [FRAC-1:0]      rd_frac;
    logic signed [EW-1:0] rd_exp;
    logic [TYPE-1:0]      rd_res_d;
    logic [4:0]           rd_flags_d;

    always_comb begin
        rd_mant  = quo_q[QW-1:2];
        rd_g     = quo_q[1];
        rd_r     = quo_q[0];
        rd_s     = |rem_q;
        rd_inc   = rd_g & (rd_r | rd_s | rd_mant[0]);
        rd_sum   = {1'b0, rd_mant} + {{(FRAC+1){1'b0}}, rd_inc};
        rd_carry = rd_sum[FRAC+1];
        rd_frac  = rd_carry ? rd_sum[FRAC:1] : rd_sum[FRAC-1:0];
        rd_exp   = rd_carry ? exp_q + ONE_S : exp_q;
        rd_res_d   = '0;
        rd_flags_d = '0;
        if (rd_exp >= MAX_S) begin
            rd_res_d            = {sign_q, INF[TYPE-2:0]};
            rd_flags_d[FLAG_OF] = 1'b1;
            rd_flags_d[FLAG_NX] = 1'b1;
        end else if (rd_exp < ONE_S) begin
            rd_res_d            = {sign_q, {(TYPE-1){1'b0}}};
            rd_flags_d[FLAG_UF] = 1'b1;
            rd_flags_d[FLAG_NX] = 1'b1;
        end else begin
            rd_res_d            = {sign_q, rd_exp[EXP-1:0], rd_frac};
            rd_flags_d[FLAG_NX] = rd_g | rd_r | rd_s;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples its pre-edge inputs, independent of order.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid) state_d = ST_UNPACK;
            ST_UNPACK: if (phase_q)  state_d = special_d ? ST_DONE : ST_DIVIDE;
            ST_DIVIDE: if (cnt_q == LAST) state_d = ST_ROUND;
            ST_ROUND:  state_d = ST_DONE;
            ST_DONE:   if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == ST_IDLE);
        out_valid    = (state_q == ST_DONE);
        result_bits  = result_q;
        except_flags = flags_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE:   phase_q <= 1'b0;
                ST_UNPACK: begin
                    phase_q <= 1'b1;
                    if (phase_q && special_d) begin
                        result_q <= sp_res_d;
                        flags_q  <= sp_flags_d;
                    end
                end
                ST_ROUND: begin
                    result_q <= rd_res_d;
                    flags_q  <= rd_flags_d;
                end
                default: ;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; the FSM never reads them
    // before loading them, which keeps reset fan-out on the control path only.
    always_ff @(posedge clk) begin
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_q <= a_bits;
                    b_q <= b_bits;
                end
            end
            ST_UNPACK: begin
                if (!phase_q) begin
                    sa_q <= ua_sign;  sb_q <= ub_sign;
                    ca_q <= ua_cls;   cb_q <= ub_cls;
                    ea_q <= ua_exp;   eb_q <= ub_exp;
                    ma_q <= ua_mant;  mb_q <= ub_mant;
                end else begin
                    sign_q <= q_sign;
                    exp_q  <= exp_pre_d;
                    rem_q  <= rem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= CW'(1);
                end
            end
            ST_DIVIDE: begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

endmodule
